// File: rtl/frac_clken_gen_if.sv
// Configuration handshake bundle for frac_clken_gen.
// The block takes cfg_wr only in a cycle where it drives cfg_ready high.
interface frac_clken_gen_if #(
    parameter int NUM_CH = 2,
    parameter int ACC_W  = 16
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             cfg_wr;
    logic [CH_W-1:0]  cfg_ch;
    logic [ACC_W-1:0] cfg_num;
    logic [ACC_W-1:0] cfg_den;
    logic             cfg_ready;

    modport master (
        output cfg_wr,
        output cfg_ch,
        output cfg_num,
        output cfg_den,
        input  cfg_ready
    );

    modport slave (
        input  cfg_wr,
        input  cfg_ch,
        input  cfg_num,
        input  cfg_den,
        output cfg_ready
    );
endinterface

// File: rtl/frac_clken_gen.sv
// Multi-channel fractional clock-enable generator (ce = refclk * num/den).
// Define CLKEN_DIVCLK_EN to add the per-channel toggling clk_div output.
module frac_clken_gen #(
    parameter int NUM_CH      = 2,
    parameter int ACC_W       = 16,
    parameter int LOCK_CYCLES = 1024
) (
    input  logic              refclk,
    input  logic              rst_n,
    frac_clken_gen_if.slave   cfg,
    output logic [NUM_CH-1:0] ce_out,
`ifdef CLKEN_DIVCLK_EN
    output logic [NUM_CH-1:0] clk_div,
`endif
    output logic              locked
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(LOCK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    typedef enum logic {
        ST_SETTLE,
        ST_RUN
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic run;
    logic ch_ok;
    logic accept;
    logic step;

    logic [ACC_W-1:0] num_q [NUM_CH];
    logic [ACC_W-1:0] den_q [NUM_CH];
    logic [ACC_W-1:0] acc_q [NUM_CH];
    logic [ACC_W-1:0] acc_d [NUM_CH];
    logic [ACC_W-1:0] eff   [NUM_CH];
    logic [ACC_W:0]   sum   [NUM_CH];
    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] hit;

    assign run    = (state_q == ST_RUN);
    assign ch_ok  = 32'(cfg.cfg_ch) < NUM_CH;
    assign accept = run && cfg.cfg_wr && ch_ok;
    // Accumulate only in RUN cycles that do not start a relock.
    assign step   = run && !accept;

    assign cfg.cfg_ready = run;
    assign locked        = run;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_SETTLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_SETTLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Rates above 1 clamp to num=den; acc < den keeps sum within ACC_W+1.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            acc_d[i] = '0;
            eff[i]   = (num_q[i] < den_q[i]) ? num_q[i] : den_q[i];
            sum[i]   = {1'b0, acc_q[i]} + {1'b0, eff[i]};
            en[i]    = (num_q[i] != '0) && (den_q[i] != '0);
            hit[i]   = step && en[i] && (sum[i] >= {1'b0, den_q[i]});
            if (step && en[i]) begin
                if (hit[i]) begin
                    acc_d[i] = ACC_W'(sum[i] - {1'b0, den_q[i]});
                end else begin
                    acc_d[i] = sum[i][ACC_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                num_q[i] <= '0;
                den_q[i] <= '0;
                acc_q[i] <= '0;
            end
            ce_out <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (accept && (cfg.cfg_ch == CH_W'(i))) begin
                    num_q[i] <= cfg.cfg_num;
                    den_q[i] <= cfg.cfg_den;
                end
                acc_q[i] <= acc_d[i];
            end
            ce_out <= hit;
        end
    end

`ifdef CLKEN_DIVCLK_EN
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            clk_div <= '0;
        end else if (step) begin
            clk_div <= clk_div ^ hit;
        end else begin
            clk_div <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_frac_clken_gen.sv
// Bench for frac_clken_gen: directed relock/rate steps plus random rates,
// checked against floor(t*n/d) pulse arithmetic.
module tb_frac_clken_gen;
    localparam int NCH  = 2;
    localparam int AW   = 16;
    localparam int LOCK = 16;

    logic refclk;
    logic rst_n;

    logic [NCH-1:0] ce_out;
    logic           locked;
    logic [2:0]     ce3;
    logic           locked3;
`ifdef CLKEN_DIVCLK_EN
    logic [NCH-1:0] clk_div;
    logic [2:0]     clk_div3;
`endif

    frac_clken_gen_if #(.NUM_CH(NCH), .ACC_W(AW)) cfg_if ();
    frac_clken_gen_if #(.NUM_CH(3), .ACC_W(AW)) cfg3_if ();

    frac_clken_gen #(
        .NUM_CH(NCH),
        .ACC_W(AW),
        .LOCK_CYCLES(LOCK)
    ) u_dut (
        .refclk (refclk),
        .rst_n  (rst_n),
        .cfg    (cfg_if.slave),
        .ce_out (ce_out),
`ifdef CLKEN_DIVCLK_EN
        .clk_div(clk_div),
`endif
        .locked (locked)
    );

    frac_clken_gen #(
        .NUM_CH(3),
        .ACC_W(AW),
        .LOCK_CYCLES(LOCK)
    ) u_dut3 (
        .refclk (refclk),
        .rst_n  (rst_n),
        .cfg    (cfg3_if.slave),
        .ce_out (ce3),
`ifdef CLKEN_DIVCLK_EN
        .clk_div(clk_div3),
`endif
        .locked (locked3)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    int     n_cmp = 0;
    int     n_bad = 0;
    longint mn [NCH];
    longint md [NCH];
    int     pcnt [NCH];

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint eff_of(input longint n, input longint d);
        return (n < d) ? n : d;
    endfunction

    // Pulses seen in t=1..T are floor(T*n/d).
    function automatic longint pulses(input longint t, input longint n,
                                      input longint d);
        if (n == 0 || d == 0) return 0;
        return (t * eff_of(n, d)) / d;
    endfunction

    task automatic settle(input int bogus_at);
        check("settle_locked0", {63'd0, locked}, 64'd0);
        check("settle_ready0", {63'd0, cfg_if.cfg_ready}, 64'd0);
        for (int k = 1; k <= LOCK; k++) begin
            if (k == bogus_at) begin
                cfg_if.cfg_wr  = 1'b1;
                cfg_if.cfg_ch  = 1'b1;
                cfg_if.cfg_num = 16'd7;
                cfg_if.cfg_den = 16'd3;
            end
            @(negedge refclk);
            cfg_if.cfg_wr = 1'b0;
            check($sformatf("settle_locked_k%0d", k), {63'd0, locked},
                  {63'd0, k == LOCK});
            check($sformatf("settle_ready_k%0d", k),
                  {63'd0, cfg_if.cfg_ready}, {63'd0, k == LOCK});
            check($sformatf("settle_ce_k%0d", k), {62'd0, ce_out}, 64'd0);
`ifdef CLKEN_DIVCLK_EN
            check($sformatf("settle_div_k%0d", k), {62'd0, clk_div}, 64'd0);
`endif
        end
    endtask

    task automatic run_span(input int span);
        for (int c = 0; c < NCH; c++) pcnt[c] = 0;
        for (int t = 1; t <= span; t++) begin
            @(negedge refclk);
            check($sformatf("run_locked_t%0d", t), {63'd0, locked}, 64'd1);
            for (int c = 0; c < NCH; c++) begin
                longint e;
                e = pulses(t, mn[c], md[c]) - pulses(t - 1, mn[c], md[c]);
                check($sformatf("ce%0d_t%0d_n%0d_d%0d", c, t, mn[c], md[c]),
                      {63'd0, ce_out[c]}, e);
                pcnt[c] += int'(ce_out[c]);
`ifdef CLKEN_DIVCLK_EN
                check($sformatf("div%0d_t%0d", c, t), {63'd0, clk_div[c]},
                      pulses(t, mn[c], md[c]) % 2);
`endif
            end
        end
    endtask

    task automatic do_write(input int ch, input longint num, input longint den,
                            input int bogus_at);
        check("wr_ready", {63'd0, cfg_if.cfg_ready}, 64'd1);
        cfg_if.cfg_wr  = 1'b1;
        cfg_if.cfg_ch  = 1'(ch);
        cfg_if.cfg_num = 16'(num);
        cfg_if.cfg_den = 16'(den);
        @(negedge refclk);
        cfg_if.cfg_wr = 1'b0;
        mn[ch] = num;
        md[ch] = den;
        settle(bogus_at);
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_if.cfg_wr = 1'b0;
        cfg_if.cfg_ch = '0;
        cfg_if.cfg_num = '0;
        cfg_if.cfg_den = '0;
        cfg3_if.cfg_wr = 1'b0;
        cfg3_if.cfg_ch = '0;
        cfg3_if.cfg_num = '0;
        cfg3_if.cfg_den = '0;
        for (int c = 0; c < NCH; c++) begin
            mn[c] = 0;
            md[c] = 0;
        end

        // T1: reset, lock timing, channels disabled
        repeat (5) @(negedge refclk);
        check("rst_ce", {62'd0, ce_out}, 64'd0);
        check("rst_locked", {63'd0, locked}, 64'd0);
        check("rst_ready", {63'd0, cfg_if.cfg_ready}, 64'd0);
        rst_n = 1'b1;
        settle(0);
        run_span(8);

        // T2: ch0 1/2, ch1 3/8
        do_write(0, 1, 2, 0);
        do_write(1, 3, 8, 0);
        run_span(16);
        check("t2_ch0_pulses16", 64'(pcnt[0]), 64'd8);
        check("t2_ch1_pulses16", 64'(pcnt[1]), 64'd6);

        // T3: num>=den on both channels
        do_write(0, 5, 5, 0);
        do_write(1, 9, 4, 0);
        run_span(10);

        // T4: write during SETTLE is ignored
        do_write(0, 2, 3, 5);
        run_span(12);

        // T5: async reset mid-RUN
        do_write(0, 1, 2, 0);
        run_span(6);
        rst_n = 1'b0;
        #1;
        check("t5_async_ce", {62'd0, ce_out}, 64'd0);
        check("t5_async_locked", {63'd0, locked}, 64'd0);
        check("t5_async_ready", {63'd0, cfg_if.cfg_ready}, 64'd0);
`ifdef CLKEN_DIVCLK_EN
        check("t5_async_div", {62'd0, clk_div}, 64'd0);
`endif
        for (int c = 0; c < NCH; c++) begin
            mn[c] = 0;
            md[c] = 0;
        end
        repeat (3) @(negedge refclk);
        rst_n = 1'b1;
        settle(0);
        run_span(8);

        // Random rates, including zero and near-full-scale values
        for (int it = 0; it < 16; it++) begin
            int     ch;
            int     mode;
            longint n;
            longint d;
            ch   = int'($urandom_range(0, 1));
            mode = int'($urandom_range(0, 9));
            if (mode == 0) begin
                n = 0;
                d = longint'($urandom_range(1, 65535));
            end else if (mode == 1) begin
                n = longint'($urandom_range(1, 65535));
                d = 0;
            end else if (mode <= 3) begin
                d = longint'($urandom_range(60000, 65535));
                n = longint'($urandom_range(0, 65535));
                if (n == 0) n = d - 1;
            end else begin
                d = longint'($urandom_range(1, 12));
                n = longint'($urandom_range(1, 14));
            end
            do_write(ch, n, d, (mode == 5) ? 7 : 0);
            run_span(int'($urandom_range(8, 40)));
        end

        // cfg_ch beyond NUM_CH is ignored; a valid channel relocks
        @(negedge refclk);
        check("oob_pre_locked", {63'd0, locked3}, 64'd1);
        cfg3_if.cfg_wr  = 1'b1;
        cfg3_if.cfg_ch  = 2'd3;
        cfg3_if.cfg_num = 16'd1;
        cfg3_if.cfg_den = 16'd2;
        @(negedge refclk);
        cfg3_if.cfg_wr = 1'b0;
        for (int k = 0; k < 20; k++) begin
            check($sformatf("oob_locked_k%0d", k), {63'd0, locked3}, 64'd1);
            check($sformatf("oob_ce_k%0d", k), {61'd0, ce3}, 64'd0);
            @(negedge refclk);
        end
        cfg3_if.cfg_wr  = 1'b1;
        cfg3_if.cfg_ch  = 2'd2;
        cfg3_if.cfg_num = 16'd1;
        cfg3_if.cfg_den = 16'd1;
        @(negedge refclk);
        cfg3_if.cfg_wr = 1'b0;
        check("ch2_relock_fall", {63'd0, locked3}, 64'd0);
        repeat (LOCK) @(negedge refclk);
        check("ch2_relock_rise", {63'd0, locked3}, 64'd1);
        check("ch2_t0_ce", {61'd0, ce3}, 64'd0);
        for (int t = 1; t <= 4; t++) begin
            @(negedge refclk);
            check($sformatf("ch2_ce_t%0d", t), {61'd0, ce3}, 64'd4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
